// File: rtl/bpf_inst_loader.sv
// BPF instruction loader: pairs inst_low/inst_high writes into 64-bit instruction memory writes,
// sequences LOAD/RUN/STOPPING from Control.start and keeps the dropped-packet counter.
// Optional macro BPF_LOADER_OVERFLOW_CHECK_EN suppresses writes past the memory end and adds load_overflow.
module bpf_inst_loader #(
  parameter int CODE_ADDR_WIDTH = 10
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic                       inst_low_strobe,
  input  logic [31:0]                inst_low_value,
  input  logic                       inst_high_strobe,
  input  logic [31:0]                inst_high_value,
  input  logic                       control_strobe,
  input  logic                       control_start,
  input  logic                       status_strobe,
  output logic [15:0]                status_num_packets_dropped,
  input  logic                       packet_dropped,
  input  logic                       cpu_idle,
  output logic                       cpu_enable,
  output logic                       inst_wr_en,
  output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
  output logic [63:0]                inst_wr_data
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
  ,
  output logic                       load_overflow
`endif
);

`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
  localparam int CNT_W = CODE_ADDR_WIDTH + 1;
`else
  localparam int CNT_W = CODE_ADDR_WIDTH;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_STOPPING
  } state_t;

  state_t                  state_reg;
  logic [31:0]             low_latch_reg;
  logic [CNT_W-1:0]        addr_cnt_reg;
  logic [31:0]             low_word;
  logic                    commit;
  logic                    counter_clear;
  logic                    mem_full;

  always_comb begin
    low_word = inst_low_strobe ? inst_low_value : low_latch_reg;
    commit   = inst_high_strobe && (state_reg == ST_LOAD);
    counter_clear = 1'b0;
    if (state_reg == ST_LOAD && control_strobe && !control_start)
      counter_clear = 1'b1;
    if (state_reg == ST_STOPPING && !(control_strobe && control_start) && cpu_idle)
      counter_clear = 1'b1;
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
    // The counter never passes 2^CODE_ADDR_WIDTH, so its MSB alone marks a full memory.
    mem_full = addr_cnt_reg[CNT_W-1];
`else
    mem_full = 1'b0;
`endif
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_reg     <= ST_LOAD;
      low_latch_reg <= '0;
      addr_cnt_reg  <= '0;
      cpu_enable    <= 1'b0;
      inst_wr_en    <= 1'b0;
      inst_wr_addr  <= '0;
      inst_wr_data  <= '0;
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
      load_overflow <= 1'b0;
`endif
    end else begin
      if (inst_low_strobe)
        low_latch_reg <= inst_low_value;
      inst_wr_en <= 1'b0;

      case (state_reg)
        ST_LOAD: begin
          if (control_strobe && control_start) begin
            state_reg  <= ST_RUN;
            cpu_enable <= 1'b1;
          end
        end
        ST_RUN: begin
          if (control_strobe && !control_start) begin
            state_reg  <= ST_STOPPING;
            cpu_enable <= 1'b0;
          end
        end
        ST_STOPPING: begin
          if (control_strobe && control_start) begin
            state_reg  <= ST_RUN;
            cpu_enable <= 1'b1;
          end else if (cpu_idle) begin
            state_reg <= ST_LOAD;
          end
        end
        default: begin
          state_reg  <= ST_LOAD;
          cpu_enable <= 1'b0;
        end
      endcase

      if (commit) begin
        if (mem_full) begin
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
          load_overflow <= 1'b1;
`endif
        end else begin
          inst_wr_en   <= 1'b1;
          inst_wr_addr <= addr_cnt_reg[CODE_ADDR_WIDTH-1:0];
          inst_wr_data <= {inst_high_value, low_word};
          addr_cnt_reg <= addr_cnt_reg + CNT_ONE;
        end
      end

      // A counter reset overrides a simultaneous advance.
      if (counter_clear) begin
        addr_cnt_reg <= '0;
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
        load_overflow <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      status_num_packets_dropped <= '0;
    end else if (status_strobe) begin
      status_num_packets_dropped <= packet_dropped ? 16'd1 : 16'd0;
    end else if (packet_dropped && status_num_packets_dropped != 16'hFFFF) begin
      status_num_packets_dropped <= status_num_packets_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_bpf_inst_loader.sv
// Scoreboard bench for bpf_inst_loader: expected writes are queued at stimulus time and
// matched by a negedge monitor; control and drop-counter behaviour is checked directly.
module tb_bpf_inst_loader;
  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn = 1'b0;
  logic          inst_low_strobe = 1'b0;
  logic [31:0]   inst_low_value = '0;
  logic          inst_high_strobe = 1'b0;
  logic [31:0]   inst_high_value = '0;
  logic          control_strobe = 1'b0;
  logic          control_start = 1'b0;
  logic          status_strobe = 1'b0;
  logic [15:0]   status_num_packets_dropped;
  logic          packet_dropped = 1'b0;
  logic          cpu_idle = 1'b0;
  logic          cpu_enable;
  logic          inst_wr_en;
  logic [AW-1:0] inst_wr_addr;
  logic [63:0]   inst_wr_data;
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
  logic          load_overflow;
`endif

  int  total = 0;
  int  bad = 0;
  wr_t exp_q[$];

  bpf_inst_loader #(.CODE_ADDR_WIDTH(AW)) dut (
    .axi_aclk                  (axi_aclk),
    .axi_aresetn               (axi_aresetn),
    .inst_low_strobe           (inst_low_strobe),
    .inst_low_value            (inst_low_value),
    .inst_high_strobe          (inst_high_strobe),
    .inst_high_value           (inst_high_value),
    .control_strobe            (control_strobe),
    .control_start             (control_start),
    .status_strobe             (status_strobe),
    .status_num_packets_dropped(status_num_packets_dropped),
    .packet_dropped            (packet_dropped),
    .cpu_idle                  (cpu_idle),
    .cpu_enable                (cpu_enable),
    .inst_wr_en                (inst_wr_en),
    .inst_wr_addr              (inst_wr_addr),
    .inst_wr_data              (inst_wr_data)
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
    ,
    .load_overflow             (load_overflow)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic low_wr(input logic [31:0] v);
    inst_low_strobe = 1'b1;
    inst_low_value  = v;
    tick();
    inst_low_strobe = 1'b0;
  endtask

  task automatic high_wr(input logic [31:0] v, input bit expect_wr,
                         input logic [AW-1:0] ea, input logic [63:0] ed);
    if (expect_wr) exp_q.push_back('{addr: ea, data: ed});
    inst_high_strobe = 1'b1;
    inst_high_value  = v;
    tick();
    inst_high_strobe = 1'b0;
  endtask

  task automatic ctrl(input logic start);
    control_strobe = 1'b1;
    control_start  = start;
    tick();
    control_strobe = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge axi_aclk) begin
    if (axi_aresetn && inst_wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required none", inst_wr_addr, inst_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(inst_wr_addr), 64'(e.addr));
        check("wr_data", inst_wr_data, e.data);
      end
    end
  end

  initial begin
    repeat (3) tick();
    axi_aresetn = 1'b1;
    tick();
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_wr_en", 64'(inst_wr_en), 64'd0);
    check("rst_wr_addr", 64'(inst_wr_addr), 64'd0);
    check("rst_wr_data", inst_wr_data, 64'd0);
    check("rst_drops", 64'(status_num_packets_dropped), 64'd0);
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
    check("rst_overflow", 64'(load_overflow), 64'd0);
`endif

    // Basic pairing and auto-increment
    low_wr(32'h0000_0015);
    high_wr(32'h0000_0800, 1'b1, 2'd0, 64'h0000_0800_0000_0015);
    tick();
    low_wr(32'h1234_5678);
    high_wr(32'h9ABC_DEF0, 1'b1, 2'd1, 64'h9ABC_DEF0_1234_5678);
    tick();

    // Same-cycle low/high uses the incoming low word
    exp_q.push_back('{addr: 2'd2, data: 64'h0000_0005_AAAA_0001});
    inst_low_strobe  = 1'b1;
    inst_low_value   = 32'hAAAA_0001;
    inst_high_strobe = 1'b1;
    inst_high_value  = 32'h0000_0005;
    tick();
    inst_low_strobe  = 1'b0;
    inst_high_strobe = 1'b0;
    tick();

    // LOAD -> RUN, writes ignored in RUN
    check("load_cpu_enable", 64'(cpu_enable), 64'd0);
    ctrl(1'b1);
    check("run_cpu_enable", 64'(cpu_enable), 64'd1);
    high_wr(32'hDEAD_BEEF, 1'b0, '0, '0);
    ctrl(1'b1);
    check("run_rewrite_enable", 64'(cpu_enable), 64'd1);

    // RUN -> STOPPING, held while busy
    cpu_idle = 1'b0;
    ctrl(1'b0);
    repeat (5) tick();
    check("stopping_enable", 64'(cpu_enable), 64'd0);
    // start=1 wins over cpu_idle in STOPPING
    cpu_idle = 1'b1;
    ctrl(1'b1);
    check("stop_restart_enable", 64'(cpu_enable), 64'd1);
    cpu_idle = 1'b0;
    ctrl(1'b0);
    check("stopping2_enable", 64'(cpu_enable), 64'd0);
    cpu_idle = 1'b1;
    tick();
    cpu_idle = 1'b0;
    check("back_to_load_enable", 64'(cpu_enable), 64'd0);
    // Counter was reset on STOPPING->LOAD; low latch still holds 0xAAAA0001
    high_wr(32'h0000_0042, 1'b1, 2'd0, 64'h0000_0042_AAAA_0001);
    tick();

    // Counter reset via start=0, then five commits into a 4-deep memory
    ctrl(1'b0);
    low_wr(32'h0000_1000);
    for (int i = 0; i < 5; i++) begin
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
      high_wr(32'(i), i < 4, 2'(i), {32'(i), 32'h0000_1000});
`else
      high_wr(32'(i), 1'b1, 2'(i), {32'(i), 32'h0000_1000});
`endif
    end
    tick();
`ifdef BPF_LOADER_OVERFLOW_CHECK_EN
    check("overflow_set", 64'(load_overflow), 64'd1);
    ctrl(1'b0);
    check("overflow_cleared", 64'(load_overflow), 64'd0);
`endif

    // Drop counter: single pulse, saturation, clear-on-read
    packet_dropped = 1'b1;
    tick();
    check("drop_one", 64'(status_num_packets_dropped), 64'd1);
    repeat (65537) tick();
    packet_dropped = 1'b0;
    check("drop_saturated", 64'(status_num_packets_dropped), 64'hFFFF);
    status_strobe  = 1'b1;
    packet_dropped = 1'b1;
    tick();
    packet_dropped = 1'b0;
    check("read_with_drop", 64'(status_num_packets_dropped), 64'd1);
    tick();
    status_strobe = 1'b0;
    check("read_alone", 64'(status_num_packets_dropped), 64'd0);

    // Reset mid-RUN
    packet_dropped = 1'b1;
    tick();
    packet_dropped = 1'b0;
    ctrl(1'b1);
    check("prereset_enable", 64'(cpu_enable), 64'd1);
    high_wr(32'h0000_0055, 1'b0, '0, '0);
    axi_aresetn = 1'b0;
    #1;
    check("arst_enable", 64'(cpu_enable), 64'd0);
    check("arst_wr_en", 64'(inst_wr_en), 64'd0);
    check("arst_wr_addr", 64'(inst_wr_addr), 64'd0);
    check("arst_wr_data", inst_wr_data, 64'd0);
    check("arst_drops", 64'(status_num_packets_dropped), 64'd0);
    tick();
    axi_aresetn = 1'b1;
    tick();
    check("post_reset_enable", 64'(cpu_enable), 64'd0);
    high_wr(32'h0000_0077, 1'b1, 2'd0, 64'h0000_0077_0000_0000);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bpf_inst_loader.md
# bpf_inst_loader

Control-side stage directly downstream of the packet filter AXI-Lite register file. It pairs `inst_low`/`inst_high` register writes into 64-bit BPF instructions and writes them into the filter CPU's instruction memory at an auto-incrementing address. It also runs the LOAD/RUN/STOPPING sequence that gates the CPU from the `Control.start` bit, and keeps the saturating dropped-packet counter that feeds the `Status` register.

## Interface
Parameters:
- `CODE_ADDR_WIDTH`, 10, instruction memory address width; depth = 2^CODE_ADDR_WIDTH.

Ports:
- `axi_aclk`  in  1  sole clock; all logic is rising-edge.
- `axi_aresetn`  in  1  asynchronous, active-low reset.
- `inst_low_strobe`  in  1  one-cycle pulse: `inst_low` register written.
- `inst_low_value`  in  32  low word (BPF code/jt/jf).
- `inst_high_strobe`  in  1  one-cycle pulse: `inst_high` register written; commits an instruction.
- `inst_high_value`  in  32  high word (BPF k).
- `control_strobe`  in  1  one-cycle pulse: `Control` register written.
- `control_start`  in  1  `Control.start` value.
- `status_strobe`  in  1  one-cycle pulse: `Status` register read.
- `status_num_packets_dropped`  out  16  dropped-packet count.
- `packet_dropped`  in  1  one-cycle pulse per packet dropped by the filter.
- `cpu_idle`  in  1  high when the filter CPU is between packets.
- `cpu_enable`  out  1  allows the CPU to accept packets.
- `inst_wr_en`  out  1  instruction memory write enable.
- `inst_wr_addr`  out  CODE_ADDR_WIDTH  write address.
- `inst_wr_data`  out  64  {inst_high_value, latched low}.
- `load_overflow`  out  1  sticky overflow flag; present only with the macro.

## Operation
- Low latch: `inst_low_strobe` captures `inst_low_value`. The latch resets to 0 and is never cleared by a commit.
- Commit: `inst_high_strobe` in LOAD writes {high, low latch} at the address counter, then increments the counter.
  - If both strobes arrive in the same cycle, the incoming low value is used (bypass).
- Strobes in RUN or STOPPING are ignored. The low latch still updates.
- State machine (reset state LOAD):
  - LOAD: `cpu_enable`=0.
    - `control_strobe` with start=1 -> RUN.
    - `control_strobe` with start=0 -> stay in LOAD; counter resets to 0.
  - RUN: `cpu_enable`=1.
    - `control_strobe` with start=0 -> STOPPING.
    - start=1 rewrite -> no effect.
  - STOPPING: `cpu_enable`=0.
    - `cpu_idle`=1 -> LOAD; counter resets to 0.
    - `control_strobe` with start=1 -> RUN; takes priority over `cpu_idle`.
- Drop counter: increments on `packet_dropped` and saturates at 16'hFFFF.
  - `status_strobe` clears it (clear-on-read).
  - Read and drop in the same cycle -> counter becomes 1.
  - Read at saturation with no drop -> 0.

## Timing
- Reset values: `cpu_enable`=0, `inst_wr_en`=0, `inst_wr_addr`=0, `inst_wr_data`=0, `status_num_packets_dropped`=0, `load_overflow`=0, state=LOAD, counter=0.
- All outputs are registered.
- Commit: `inst_wr_en` pulses exactly one cycle, in the cycle after `inst_high_strobe`, with address and data valid in that cycle.
  - The counter advances in that same edge.
  - Back-to-back high strobes -> back-to-back writes at consecutive addresses.
- `cpu_enable` changes one cycle after the triggering strobe or `cpu_idle` sample.
- Counter reset on the LOAD start=0 strobe and on STOPPING->LOAD takes effect at the same edge as the state update.
- Mid-operation reset: everything returns to reset values asynchronously. A commit in flight is lost.
- Drop count is visible one cycle after `packet_dropped`.

## Configuration
- `BPF_LOADER_OVERFLOW_CHECK_EN` defined:
  - The counter is CODE_ADDR_WIDTH+1 bits.
  - A commit when counter = 2^CODE_ADDR_WIDTH produces no `inst_wr_en` and sets sticky `load_overflow`.
  - `load_overflow` clears only on a counter reset (LOAD start=0 strobe, STOPPING->LOAD) or `axi_aresetn`.
- Undefined:
  - The `load_overflow` port is absent.
  - The counter is CODE_ADDR_WIDTH bits and wraps from 2^CODE_ADDR_WIDTH-1 to 0, overwriting address 0.

## Test plan
- Reset, then low=0x00000015, then high=0x00000800 -> one `inst_wr_en` pulse, addr 0, data 0x0000080000000015; a second pair -> addr 1.
- Same-cycle low=0xAAAA0001 and high=0x5 -> data 0x00000005AAAA0001; start=1 strobe -> `cpu_enable`=1 one cycle later; high strobe in RUN -> no write.
- In RUN, strobe start=0 with `cpu_idle`=0 for 5 cycles -> STOPPING, `cpu_enable`=0; raise `cpu_idle` -> LOAD; next commit goes to addr 0.
- 0xFFFF+3 drop pulses -> count holds 0xFFFF; `status_strobe` together with a drop -> 1; `status_strobe` alone -> 0.
- CODE_ADDR_WIDTH=2, five commits: with macro -> writes at addr 0..3, fifth suppressed, `load_overflow`=1; without macro -> fifth write at addr 0.
- Assert `axi_aresetn` low mid-RUN, one cycle after `inst_high_strobe` -> all outputs at reset values immediately; after release -> state LOAD, counter 0.
